// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, start/data/parity/stop FSM,
// single-entry output holding register with valid/ready handshake and overrun flag.
module uart_rx #(
  parameter int P_SYS_CLK        = 50000000,
  parameter int P_UART_BAUD_RATE = 115200,
  parameter int P_DATA_BITS      = 8,
  parameter int P_PARITY         = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_rx,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int DIV   = P_SYS_CLK / P_UART_BAUD_RATE;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [2:0]       BIT_LAST = 3'(P_DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_m, rx_s, rx_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       sh_q;
  logic             par_err_q;
  logic [7:0]       rx_byte;
  logic             fall, tick;
  logic             cnt_clr, shift_en, par_en, load;

  // Odd mode flags an even overall count of ones, even mode an odd count.
  function automatic logic parity_err(input logic [7:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (P_PARITY == 1) ? ~x : x;
  endfunction

  assign fall    = rx_d & ~rx_s;
  assign tick    = (cnt_q == CNT_LAST);
  // Bits enter at the MSB, so a short frame must be shifted down to LSB-align it.
  assign rx_byte = sh_q >> (8 - P_DATA_BITS);
  assign o_busy  = (state_q != IDLE);

  // Stage: input synchronizer and edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_q == BIT_LAST) state_d = (P_PARITY != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) begin
          par_en  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage: bit timing and deserialisation
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_clr || tick) ? '0 : cnt_q + 1'b1;
      if (shift_en)              bit_q <= bit_q + 1'b1;
      else if (state_q != DATA)  bit_q <= '0;
      if (par_en) par_err_q <= parity_err(rx_byte, rx_s);
    end
  end

  always_ff @(posedge clock) begin
    if (shift_en) sh_q <= {rx_s, sh_q[7:1]};
  end

  // Stage: output holding register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= load & o_valid & ~i_ready;
      if (load) begin
        o_data       <= rx_byte;
        o_valid      <= 1'b1;
        o_parity_err <= (P_PARITY != 0) & par_err_q;
        o_frame_err  <= ~rx_s;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance at DIV=10, checked every
// cycle against a frame-level model plus directed literal expectations.
module tb_uart_rx;

  localparam int SYS  = 1000000;
  localparam int BAUD = 100000;
  localparam int DIV  = SYS / BAUD;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx_n  = 1'b1;
  logic       rx_e  = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data_n, data_e;
  logic       valid_n, valid_e, pe_n, pe_e, fe_n, fe_e, ov_n, ov_e, busy_n, busy_e;

  uart_rx #(.P_SYS_CLK(SYS), .P_UART_BAUD_RATE(BAUD), .P_DATA_BITS(8), .P_PARITY(0)) dut_n (
    .clock(clock), .reset(reset), .i_rx(rx_n), .i_ready(ready),
    .o_data(data_n), .o_valid(valid_n), .o_parity_err(pe_n), .o_frame_err(fe_n),
    .o_overrun(ov_n), .o_busy(busy_n));

  uart_rx #(.P_SYS_CLK(SYS), .P_UART_BAUD_RATE(BAUD), .P_DATA_BITS(8), .P_PARITY(2)) dut_e (
    .clock(clock), .reset(reset), .i_rx(rx_e), .i_ready(ready),
    .o_data(data_e), .o_valid(valid_e), .o_parity_err(pe_e), .o_frame_err(fe_e),
    .o_overrun(ov_e), .o_busy(busy_e));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: each frame sent yields one byte at a known edge.
  typedef struct {int at; logic [7:0] d; logic pe; logic fe;} exp_t;
  exp_t q_n[$];
  exp_t q_e[$];

  logic       m_v[2], m_pe[2], m_fe[2], m_ov[2];
  logic [7:0] m_d[2];
  logic       rdy_prev = 1'b1;
  exp_t       e;
  logic       hit;

  always @(negedge clock) begin
    if (!reset) begin
      q_n.delete();
      q_e.delete();
      for (int k = 0; k < 2; k++) begin
        m_v[k] = 0; m_pe[k] = 0; m_fe[k] = 0; m_ov[k] = 0; m_d[k] = 8'h00;
      end
      chk("rst_valid_n", valid_n, 0);
      chk("rst_data_n", data_n, 0);
      chk("rst_flags_n", {pe_n, fe_n, ov_n, busy_n}, 0);
      chk("rst_valid_e", valid_e, 0);
      chk("rst_flags_e", {pe_e, fe_e, ov_e, busy_e}, 0);
    end else begin
      for (int k = 0; k < 2; k++) begin
        hit = 0;
        if (k == 0 && q_n.size() > 0 && q_n[0].at == cyc) begin e = q_n.pop_front(); hit = 1; end
        if (k == 1 && q_e.size() > 0 && q_e[0].at == cyc) begin e = q_e.pop_front(); hit = 1; end
        if (hit) begin
          m_ov[k] = m_v[k] & ~rdy_prev;
          m_v[k]  = 1'b1;
          m_d[k]  = e.d;
          m_pe[k] = e.pe;
          m_fe[k] = e.fe;
        end else begin
          if (m_v[k] && rdy_prev) m_v[k] = 1'b0;
          m_ov[k] = 1'b0;
        end
      end
      chk("valid_n", valid_n, m_v[0]);
      chk("overrun_n", ov_n, m_ov[0]);
      chk("valid_e", valid_e, m_v[1]);
      chk("overrun_e", ov_e, m_ov[1]);
      if (m_v[0]) begin
        chk("data_n", data_n, m_d[0]);
        chk("perr_n", pe_n, m_pe[0]);
        chk("ferr_n", fe_n, m_fe[0]);
      end
      if (m_v[1]) begin
        chk("data_e", data_e, m_d[1]);
        chk("perr_e", pe_e, m_pe[1]);
        chk("ferr_e", fe_e, m_fe[1]);
      end
    end
    rdy_prev = ready;
  end

  // Captures of the most recent presented byte for directed checks.
  int         cnt_vn = 0, cnt_ve = 0, cnt_ov = 0;
  logic [7:0] cap_dn = 0, cap_de = 0;
  logic       cap_pen = 0, cap_fen = 0, cap_pee = 0, cap_fee = 0;

  always @(negedge clock) begin
    if (valid_n) begin cnt_vn++; cap_dn = data_n; cap_pen = pe_n; cap_fen = fe_n; end
    if (valid_e) begin cnt_ve++; cap_de = data_e; cap_pee = pe_e; cap_fee = fe_e; end
    if (ov_n) cnt_ov++;
  end

  task automatic drive(input int ch, input logic v);
    if (ch == 0) rx_n = v;
    else         rx_e = v;
  endtask

  // par: 0 none, 1 odd, 2 even. Returns one cycle before the next frame slot.
  task automatic send(input int ch, input logic [7:0] d, input int par,
                      input logic pbit, input logic stop);
    exp_t x;
    logic p;
    @(posedge clock);
    #1 drive(ch, 1'b0);
    p    = (^d) ^ pbit;
    x.at = cyc + 18 + DIV * (8 + ((par != 0) ? 1 : 0));
    x.d  = d;
    x.pe = (par == 0) ? 1'b0 : ((par == 2) ? p : ~p);
    x.fe = ~stop;
    if (ch == 0) q_n.push_back(x);
    else         q_e.push_back(x);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clock);
      #1 drive(ch, d[i]);
    end
    if (par != 0) begin
      repeat (DIV) @(posedge clock);
      #1 drive(ch, pbit);
    end
    repeat (DIV) @(posedge clock);
    #1 drive(ch, stop);
    repeat (DIV - 1) @(posedge clock);
  endtask

  logic [7:0] d55 = 8'h55;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", busy_n, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (5) @(posedge clock);

    // 8N1 byte with the consumer always ready: exactly one valid cycle
    cnt_vn = 0;
    send(0, 8'hA5, 0, 1'b0, 1'b1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("a5_pulse", 8'(cnt_vn), 8'd1);
    chk("a5_data", cap_dn, 8'hA5);
    chk("a5_flags", {cap_pen, cap_fen}, 2'b00);

    // three-cycle glitch is rejected at the mid-start sample
    cnt_vn = 0;
    @(posedge clock);
    #1 rx_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 rx_n = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("glitch_busy_hi", busy_n, 1'b1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("glitch_busy_lo", busy_n, 1'b0);
    repeat (20) @(posedge clock);
    chk("glitch_novalid", 8'(cnt_vn), 8'd0);

    // even parity: 0x0F has four ones
    send(1, 8'h0F, 2, 1'b1, 1'b1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("par1_data", cap_de, 8'h0F);
    chk("par1_perr", cap_pee, 1'b1);
    send(1, 8'h0F, 2, 1'b0, 1'b1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("par0_perr", cap_pee, 1'b0);
    chk("par0_ferr", cap_fee, 1'b0);

    // stop bit low
    send(0, 8'h3C, 0, 1'b0, 1'b0);
    #1 rx_n = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("ferr_data", cap_dn, 8'h3C);
    chk("ferr_flag", cap_fen, 1'b1);

    // overrun: two bytes with the consumer stalled
    @(posedge clock);
    #1 ready = 1'b0;
    cnt_ov = 0;
    send(0, 8'h11, 0, 1'b0, 1'b1);
    send(0, 8'h22, 0, 1'b0, 1'b1);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("ovr_count", 8'(cnt_ov), 8'd1);
    chk("ovr_valid", valid_n, 1'b1);
    chk("ovr_data", data_n, 8'h22);
    @(posedge clock);
    #1 ready = 1'b1;
    @(negedge clock);
    chk("ovr_hold", valid_n, 1'b1);
    @(negedge clock);
    chk("ovr_clear", valid_n, 1'b0);

    // reset in the middle of data bit 4 of 0x55
    cnt_vn = 0;
    @(posedge clock);
    #1 rx_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (DIV) @(posedge clock);
      #1 rx_n = d55[i];
    end
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    rx_n = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rst_mid_busy", busy_n, 1'b0);
    send(0, 8'h81, 0, 1'b0, 1'b1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rst_mid_count", 8'(cnt_vn), 8'd1);
    chk("rst_mid_data", cap_dn, 8'h81);
    chk("rst_mid_flags", {cap_pen, cap_fen}, 2'b00);

    // break: line held low past the stop sample
    cnt_vn = 0;
    send(0, 8'h00, 0, 1'b0, 1'b0);
    repeat (40) @(posedge clock);
    #1 rx_n = 1'b1;
    repeat (30) @(posedge clock);
    @(negedge clock);
    chk("break_count", 8'(cnt_vn), 8'd1);
    chk("break_data", cap_dn, 8'h00);
    chk("break_ferr", cap_fen, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter P_SYS_CLK, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter P_UART_BAUD_RATE, default 115200, serial bit rate in bps.
REQ-003 SHALL have parameter P_DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-004 SHALL have parameter P_PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_rx, input, 1, asynchronous serial line; idle high.
REQ-008 SHALL have port i_ready, input, 1, consumer accepts the held byte when high with o_valid.
REQ-009 SHALL have port o_data, output, 8, received byte, LSB-aligned; unused upper bits 0.
REQ-010 SHALL have port o_valid, output, 1, o_data holds an unaccepted byte.
REQ-011 SHALL have port o_parity_err, output, 1, parity mismatch flag for the held byte.
REQ-012 SHALL have port o_frame_err, output, 1, stop bit sampled low for the held byte.
REQ-013 SHALL have port o_overrun, output, 1, one-cycle pulse when a byte is overwritten unaccepted.
REQ-014 SHALL have port o_busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 SHALL compute DIV = P_SYS_CLK/P_UART_BAUD_RATE (integer), HALF = DIV/2, counter width $clog2(DIV).
REQ-016 SHALL pass i_rx through a 2-flop synchronizer, then one edge-detect flop; all decisions use the synchronized value rx_s.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: on rx_s falling edge -> START, bit counter cleared to 0.
REQ-019 START: when counter == HALF-1, sample rx_s; 1 -> IDLE (false start, no output), 0 -> DATA with counter cleared.
REQ-020 DATA: when counter == DIV-1, sample rx_s into shift register LSB-first, clear counter; after P_DATA_BITS samples -> PARITY if P_PARITY != 0, else STOP.
REQ-021 PARITY: when counter == DIV-1, sample parity bit; error if XOR(data bits, parity bit) is 0 for odd or 1 for even; -> STOP.
REQ-022 STOP: when counter == DIV-1, sample stop bit, then -> IDLE on the next edge (no wait for a full stop bit).
REQ-023 On the stop sample cycle, the next edge SHALL load o_data, set o_valid, o_parity_err (0 when P_PARITY==0) and o_frame_err = ~stop sample.
REQ-024 Byte delivery SHALL happen even with framing or parity error; flags qualify the byte.
REQ-025 o_valid SHALL stay high until a cycle with o_valid & i_ready; next edge clears o_valid unless a new byte loads that same edge.
REQ-026 If a new byte loads while o_valid is high and i_ready is low, SHALL overwrite o_data and flags, keep o_valid high, pulse o_overrun for one cycle.
REQ-027 If load and accept coincide, load wins: o_valid stays high, no o_overrun.
REQ-028 Bit counter SHALL wrap to 0 at DIV-1 and never exceed DIV-1.
REQ-029 Line held low through and after the stop sample (break) SHALL yield a frame error byte of 0x00, then a new frame SHALL only start after rx_s returns high and falls again.

Reset
REQ-030 Reset low SHALL asynchronously force FSM IDLE, counter 0, synchronizer flops 1, o_data 0, o_valid 0, o_parity_err 0, o_frame_err 0, o_overrun 0, o_busy 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only on a fresh falling edge.

Verification
REQ-032 P_SYS_CLK=1000000, baud 100000 (DIV=10), 8N1, send 0xA5 with i_ready=1 -> o_valid pulses one cycle, o_data=0xA5, both error flags 0.
REQ-033 Same setup, 3-cycle low glitch on i_rx -> FSM returns IDLE from START, no o_valid, o_busy low again within HALF+4 cycles.
REQ-034 P_PARITY=2, send 0x0F with parity bit 1 -> o_data=0x0F, o_parity_err=1; with parity bit 0 -> o_parity_err=0.
REQ-035 Send 0x3C with stop bit 0 -> o_data=0x3C, o_frame_err=1.
REQ-036 i_ready=0, send 0x11 then 0x22 back-to-back -> o_valid stays high, o_overrun pulses once, o_data=0x22; raising i_ready clears o_valid next edge.
REQ-037 Assert reset during data bit 4 of 0x55, release, send 0x81 -> only 0x81 delivered, no errors.
